// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_ctrl_pkg : opcodes, T-state encodings, ALU codes and strobe bundle     |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package cpu_ctrl_pkg;

    localparam int CTRL_OPW     = 5;
    localparam int CTRL_STATE_W = 4;

    localparam logic [CTRL_OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [CTRL_OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [CTRL_OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [CTRL_OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [CTRL_OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [CTRL_OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [CTRL_OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [CTRL_OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [CTRL_OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [CTRL_OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [CTRL_OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [CTRL_OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [CTRL_OPW-1:0] ALU_NONE = 5'b00000;
    localparam logic [CTRL_OPW-1:0] ALU_ADD  = 5'b00011;
    localparam logic [CTRL_OPW-1:0] ALU_AND  = 5'b00101;
    localparam logic [CTRL_OPW-1:0] ALU_OR   = 5'b00110;

    typedef enum logic [CTRL_STATE_W-1:0] {
        ST_RESET  = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_T7     = 4'd8,
        ST_HALTED = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU, CLS_ALUI, CLS_NOP, CLS_HALT, CLS_ILL
    } op_class_t;

    typedef struct packed {
        logic PCout;
        logic MARin;
        logic IncPC;
        logic Zin;
        logic ZLOout;
        logic PCin;
        logic Read;
        logic Write;
        logic MDRin;
        logic MDRout;
        logic IRin;
        logic Gra;
        logic Grb;
        logic Grc;
        logic Rin;
        logic Rout;
        logic BAout;
        logic Yin;
        logic Cout;
    } strobes_t;

    function automatic op_class_t op_class(input logic [CTRL_OPW-1:0] op);
        case (op)
            OP_LD:                          return CLS_LD;
            OP_LDI:                         return CLS_LDI;
            OP_ST:                          return CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  return CLS_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:       return CLS_ALUI;
            OP_NOP:                         return CLS_NOP;
            OP_HALT:                        return CLS_HALT;
            default:                        return CLS_ILL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_decode : combinational T-state x opcode -> datapath strobes and alu_op |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module seq_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW     = CTRL_OPW,
    parameter int STATE_W = CTRL_STATE_W
) (
    input  logic [STATE_W-1:0] state,
    input  logic               run,
    input  logic [OPW-1:0]     ir_op,
    output strobes_t           strb,
    output logic [OPW-1:0]     alu_op
);

    op_class_t w_cls;
    assign w_cls = op_class(ir_op);

    always_comb begin
        strb   = '0;
        alu_op = ALU_NONE;
        case (state)
            ST_T0: begin
                // Fetch waits in T0 with every strobe low until run is granted.
                if (run) begin
                    strb.PCout = 1'b1; strb.MARin = 1'b1;
                    strb.IncPC = 1'b1; strb.Zin   = 1'b1;
                end
            end
            ST_T1: begin
                strb.ZLOout = 1'b1; strb.PCin  = 1'b1;
                strb.Read   = 1'b1; strb.MDRin = 1'b1;
            end
            ST_T2: begin
                strb.MDRout = 1'b1; strb.IRin = 1'b1;
            end
            ST_T3: begin
                case (w_cls)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        strb.Grb = 1'b1; strb.BAout = 1'b1; strb.Yin = 1'b1;
                    end
                    CLS_ALU, CLS_ALUI: begin
                        strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Yin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_cls)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        strb.Cout = 1'b1; strb.Zin = 1'b1; alu_op = ALU_ADD;
                    end
                    CLS_ALU: begin
                        strb.Grc = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1;
                        alu_op = ir_op;
                    end
                    CLS_ALUI: begin
                        strb.Cout = 1'b1; strb.Zin = 1'b1;
                        alu_op = (ir_op == OP_ANDI) ? ALU_AND :
                                 (ir_op == OP_ORI)  ? ALU_OR  : ALU_ADD;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_cls)
                    CLS_LD, CLS_ST: begin
                        strb.ZLOout = 1'b1; strb.MARin = 1'b1;
                    end
                    CLS_LDI, CLS_ALU, CLS_ALUI: begin
                        strb.ZLOout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (w_cls == CLS_LD) begin
                    strb.Read = 1'b1; strb.MDRin = 1'b1;
                end else if (w_cls == CLS_ST) begin
                    strb.Gra = 1'b1; strb.Rout = 1'b1; strb.MDRin = 1'b1;
                end
            end
            ST_T7: begin
                if (w_cls == CLS_LD) begin
                    strb.MDRout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1;
                end else if (w_cls == CLS_ST) begin
                    strb.Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_sequencer : hardwired T-state control unit (fetch T0-T2, exec T3+) |
// | Option SEQ_MEM_WAIT_EN : T1/T6(ld)/T7(st) stall until mem_ready           |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW     = CTRL_OPW,
    parameter int STATE_W = CTRL_STATE_W
) (
    input  logic           clock,
    input  logic           clear,
    input  logic           run,
    input  logic [OPW-1:0] ir_op,
    input  logic           mem_ready,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           Zin,
    output logic           ZLOout,
    output logic           PCin,
    output logic           Read,
    output logic           Write,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           Yin,
    output logic           Cout,
    output logic [OPW-1:0] alu_op,
    output logic           halted,
    output logic           illegal_op
);

    state_t    r_state;
    logic      r_illegal_op;
    op_class_t w_cls;
    logic      w_hold;
    strobes_t  w_strb;

    assign w_cls = op_class(ir_op);

`ifdef SEQ_MEM_WAIT_EN
    assign w_hold = !mem_ready && ((r_state == ST_T1) ||
                                   (r_state == ST_T6 && w_cls == CLS_LD) ||
                                   (r_state == ST_T7 && w_cls == CLS_ST));
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_hold             = 1'b0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state      <= ST_RESET;
            r_illegal_op <= 1'b0;
        end else if (!w_hold) begin
            case (r_state)
                ST_RESET: r_state <= ST_T0;
                ST_T0:    if (run) r_state <= ST_T1;
                ST_T1:    r_state <= ST_T2;
                ST_T2:    r_state <= ST_T3;
                ST_T3: begin
                    case (w_cls)
                        CLS_NOP:  r_state <= ST_T0;
                        CLS_HALT: r_state <= ST_HALTED;
                        CLS_ILL: begin
                            r_state      <= ST_HALTED;
                            r_illegal_op <= 1'b1;
                        end
                        default:  r_state <= ST_T4;
                    endcase
                end
                ST_T4:     r_state <= ST_T5;
                ST_T5:     r_state <= (w_cls == CLS_LD || w_cls == CLS_ST) ? ST_T6 : ST_T0;
                ST_T6:     r_state <= (w_cls == CLS_LD || w_cls == CLS_ST) ? ST_T7 : ST_T0;
                ST_T7:     r_state <= ST_T0;
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_RESET;
            endcase
        end
    end

    seq_decode #(
        .OPW     (OPW),
        .STATE_W (STATE_W)
    ) u_decode (
        .state  (r_state),
        .run    (run),
        .ir_op  (ir_op),
        .strb   (w_strb),
        .alu_op (alu_op)
    );

    assign {PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, Write, MDRin, MDRout,
            IRin, Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout} = w_strb;

    assign halted     = (r_state == ST_HALTED);
    assign illegal_op = r_illegal_op;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_sequencer : directed bench for the T-state control unit        |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       run = 1'b0;
    logic [4:0] ir_op = 5'b00000;
    logic       mem_ready = 1'b1;

    logic PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, Write, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout;
    logic [4:0] alu_op;
    logic halted, illegal_op;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir_op(ir_op), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .ZLOout(ZLOout),
        .PCin(PCin), .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Yin(Yin), .Cout(Cout), .alu_op(alu_op), .halted(halted),
        .illegal_op(illegal_op)
    );

    localparam logic [18:0] S_PCOUT  = 19'd1 << 18;
    localparam logic [18:0] S_MARIN  = 19'd1 << 17;
    localparam logic [18:0] S_INCPC  = 19'd1 << 16;
    localparam logic [18:0] S_ZIN    = 19'd1 << 15;
    localparam logic [18:0] S_ZLOOUT = 19'd1 << 14;
    localparam logic [18:0] S_PCIN   = 19'd1 << 13;
    localparam logic [18:0] S_READ   = 19'd1 << 12;
    localparam logic [18:0] S_WRITE  = 19'd1 << 11;
    localparam logic [18:0] S_MDRIN  = 19'd1 << 10;
    localparam logic [18:0] S_MDROUT = 19'd1 << 9;
    localparam logic [18:0] S_IRIN   = 19'd1 << 8;
    localparam logic [18:0] S_GRA    = 19'd1 << 7;
    localparam logic [18:0] S_GRB    = 19'd1 << 6;
    localparam logic [18:0] S_GRC    = 19'd1 << 5;
    localparam logic [18:0] S_RIN    = 19'd1 << 4;
    localparam logic [18:0] S_ROUT   = 19'd1 << 3;
    localparam logic [18:0] S_BAOUT  = 19'd1 << 2;
    localparam logic [18:0] S_YIN    = 19'd1 << 1;
    localparam logic [18:0] S_COUT   = 19'd1 << 0;

    localparam logic [18:0] NONE   = 19'd0;
    localparam logic [18:0] F_T0   = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
    localparam logic [18:0] F_T1   = S_ZLOOUT | S_PCIN | S_READ | S_MDRIN;
    localparam logic [18:0] F_T2   = S_MDROUT | S_IRIN;
    localparam logic [18:0] LD_T3  = S_GRB | S_BAOUT | S_YIN;
    localparam logic [18:0] IMM_T4 = S_COUT | S_ZIN;
    localparam logic [18:0] LD_T5  = S_ZLOOUT | S_MARIN;
    localparam logic [18:0] LD_T6  = S_READ | S_MDRIN;
    localparam logic [18:0] LD_T7  = S_MDROUT | S_GRA | S_RIN;
    localparam logic [18:0] WB_T5  = S_ZLOOUT | S_GRA | S_RIN;
    localparam logic [18:0] ALU_T3 = S_GRB | S_ROUT | S_YIN;
    localparam logic [18:0] ALU_T4 = S_GRC | S_ROUT | S_ZIN;
    localparam logic [18:0] ST_T6  = S_GRA | S_ROUT | S_MDRIN;
    localparam logic [18:0] ST_T7  = S_WRITE;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [18:0] es, input logic [4:0] ea,
                         input logic eh, input logic ei);
        logic [25:0] obs;
        logic [25:0] exp;
        obs = {PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, Write, MDRin, MDRout, IRin,
               Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout, alu_op, halted, illegal_op};
        exp = {es, ea, eh, ei};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Checks T0..T2 starting in T0 and leaves the sequencer in T3.
    task automatic fetch(input string tag);
        check({tag, "_t0"}, F_T0, 5'd0, 1'b0, 1'b0);
        tick(); check({tag, "_t1"}, F_T1, 5'd0, 1'b0, 1'b0);
        tick(); check({tag, "_t2"}, F_T2, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #1 check("reset_async", NONE, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        check("reset_held", NONE, 5'd0, 1'b0, 1'b0);
        clear = 1'b1;
        tick(); check("t0_idle_after_reset", NONE, 5'd0, 1'b0, 1'b0);
        run = 1'b1;
        #1;

        // ld: eight T-states, next T0 on the ninth cycle
        ir_op = 5'b00000;
        fetch("ld");
        check("ld_t3", LD_T3, 5'd0, 1'b0, 1'b0);
        tick(); check("ld_t4", IMM_T4, 5'b00011, 1'b0, 1'b0);
        tick(); check("ld_t5", LD_T5, 5'd0, 1'b0, 1'b0);
        tick(); check("ld_t6", LD_T6, 5'd0, 1'b0, 1'b0);
        tick(); check("ld_t7", LD_T7, 5'd0, 1'b0, 1'b0);
        tick();

        ir_op = 5'b00011;
        fetch("add");
        check("add_t3", ALU_T3, 5'd0, 1'b0, 1'b0);
        tick(); check("add_t4", ALU_T4, 5'b00011, 1'b0, 1'b0);
        tick(); check("add_t5", WB_T5, 5'd0, 1'b0, 1'b0);
        tick();

        ir_op = 5'b01101;
        check("andi_t0", F_T0, 5'd0, 1'b0, 1'b0);
        tick(); tick(); tick();
        check("andi_t3", ALU_T3, 5'd0, 1'b0, 1'b0);
        tick(); check("andi_t4", IMM_T4, 5'b00101, 1'b0, 1'b0);
        tick(); check("andi_t5", WB_T5, 5'd0, 1'b0, 1'b0);
        tick();

        ir_op = 5'b00001;
        check("ldi_t0", F_T0, 5'd0, 1'b0, 1'b0);
        tick(); tick(); tick();
        check("ldi_t3", LD_T3, 5'd0, 1'b0, 1'b0);
        tick(); check("ldi_t4", IMM_T4, 5'b00011, 1'b0, 1'b0);
        tick(); check("ldi_t5", WB_T5, 5'd0, 1'b0, 1'b0);
        tick();

        // st with memory stalling in T7
        ir_op = 5'b00010;
        fetch("st");
        check("st_t3", LD_T3, 5'd0, 1'b0, 1'b0);
        tick(); check("st_t4", IMM_T4, 5'b00011, 1'b0, 1'b0);
        tick(); check("st_t5", LD_T5, 5'd0, 1'b0, 1'b0);
        tick(); check("st_t6", ST_T6, 5'd0, 1'b0, 1'b0);
        tick(); check("st_t7", ST_T7, 5'd0, 1'b0, 1'b0);
        mem_ready = 1'b0;
`ifdef SEQ_MEM_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            tick(); check("st_t7_wait", ST_T7, 5'd0, 1'b0, 1'b0);
        end
        mem_ready = 1'b1;
`endif
        tick(); check("st_done_t0", F_T0, 5'd0, 1'b0, 1'b0);
        mem_ready = 1'b1;

        // run=0 parks in T0, then a nop
        run = 1'b0;
        #1 check("idle_t0", NONE, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(); check("idle_hold", NONE, 5'd0, 1'b0, 1'b0);
        end
        run = 1'b1;
        ir_op = 5'b11010;
        #1;
        fetch("nop");
        check("nop_t3", NONE, 5'd0, 1'b0, 1'b0);
        tick(); check("nop_t0", F_T0, 5'd0, 1'b0, 1'b0);

        // reset asserted in T5 of ld
        ir_op = 5'b00000;
        tick(); tick(); tick(); tick(); tick();
        check("rst_ld_t5", LD_T5, 5'd0, 1'b0, 1'b0);
        clear = 1'b0;
        #1 check("rst_mid_async", NONE, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        check("rst_mid_held", NONE, 5'd0, 1'b0, 1'b0);
        clear = 1'b1;
        tick(); check("rst_mid_t0", F_T0, 5'd0, 1'b0, 1'b0);

        // halt
        ir_op = 5'b11011;
        tick(); tick(); tick();
        check("halt_t3", NONE, 5'd0, 1'b0, 1'b0);
        tick(); check("halt_state", NONE, 5'd0, 1'b1, 1'b0);
        tick(); check("halt_stays", NONE, 5'd0, 1'b1, 1'b0);
        clear = 1'b0;
        #1 check("halt_reset", NONE, 5'd0, 1'b0, 1'b0);
        tick(); clear = 1'b1;
        tick();

        // undefined opcode
        ir_op = 5'b11111;
        tick(); tick(); tick();
        check("ill_t3", NONE, 5'd0, 1'b0, 1'b0);
        tick(); check("ill_set", NONE, 5'd0, 1'b1, 1'b1);
        tick(); tick(); check("ill_sticky", NONE, 5'd0, 1'b1, 1'b1);
        clear = 1'b0;
        #1 check("ill_reset", NONE, 5'd0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
